// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions: opcode constants, instruction formats,
// the field bundle presented to the packer, and the packer FIFO entry.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_fields_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } fifo_entry_t;

  function automatic fmt_t opcode_fmt(input logic [6:0] opcode);
    fmt_t fmt;
    case (opcode)
      OP_R:                      fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
      OP_STORE:                  fmt = FMT_S;
      OP_BRANCH:                 fmt = FMT_B;
      OP_LUI, OP_AUIPC:          fmt = FMT_U;
      OP_JAL:                    fmt = FMT_J;
      default:                   fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_pack_comb.sv
// Combinational RV32I encoder: places register fields and the immediate into
// the instruction word and flags immediates that do not fit the format.
module instr_pack_comb
  import rv_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   instr,
  output logic          err
);

  logic [31:0] imm;
  logic        is_shift;

  assign imm      = fields.imm;
  assign is_shift = (fields.opcode == OP_IMM) &&
                    ((fields.funct3 == 3'b001) || (fields.funct3 == 3'b101));

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    instr = '0;
    err   = 1'b0;
    case (opcode_fmt(fields.opcode))
      FMT_R: begin
        instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                 fields.rd, fields.opcode};
      end
      FMT_I: begin
        if (is_shift) begin
          instr = {fields.funct7, imm[4:0], fields.rs1, fields.funct3,
                   fields.rd, fields.opcode};
          err   = |imm[31:5];
        end else begin
          instr = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
          err   = !((&imm[31:11]) || !(|imm[31:11]));
        end
      end
      FMT_S: begin
        instr = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                 imm[4:0], fields.opcode};
        err   = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                 imm[4:1], imm[11], fields.opcode};
        err   = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], fields.rd, fields.opcode};
        err   = |imm[11:0];
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        err   = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      default: begin
        instr = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: encodes field bundles, queues them in a small FIFO and
// streams words to imem with an auto-incrementing address and error count.
module instr_packer
  import rv_pkg::*;
#(
  parameter int                DEPTH     = 2,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_err,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  instr_fields_t fields;
  fifo_entry_t   enc_entry;
  fifo_entry_t   head;
  fifo_entry_t   mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              full, empty, push, pop;

  assign fields = '{opcode: in_opcode, rd: in_rd, funct3: in_funct3, rs1: in_rs1,
                    rs2: in_rs2, funct7: in_funct7, imm: in_imm};

  instr_pack_comb u_pack (
    .fields (fields),
    .instr  (enc_entry.instr),
    .err    (enc_entry.err)
  );

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full && !start;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Storage is never reset, so the head is masked to give zeros while empty.
  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head.instr : '0;
  assign out_err   = out_valid && head.err;
  assign out_addr  = addr_q;
  assign err_count = err_count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;
    if (start) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      addr_d      = BASE_ADDR;
      err_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + ADDR_W'(1);
        if (out_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= BASE_ADDR;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: the FIFO array has no reset; occupancy is tracked by count_q and the
  // output is masked, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_entry;
  end

endmodule

// File: tb/tb_instr_packer.sv
// Directed self-checking bench for instr_packer with hand-encoded expected words.
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  instr_packer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_addr  (out_addr),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_opcode = op;
    in_rd     = rd;
    in_funct3 = f3;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0);
    in_valid  = 1'b0;
    #3;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr,      32'h0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ADDI x1,x0,-1
    drive(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", out_instr, 32'hFFF0_0093);
    chk("addi_err",   32'(out_err), 32'd0);
    chk("addi_addr",  32'(out_addr), 32'd0);
    in_valid = 1'b0;
    step();
    chk("addi_popped_addr", 32'(out_addr), 32'd1);
    start = 1'b1;
    #1;
    chk("start_in_ready", 32'(in_ready), 32'd0);
    step();
    start = 1'b0;
    chk("start_addr", 32'(out_addr), 32'd0);

    // BEQ x0,x0,+8 then JAL x1,+2048 back to back
    drive(7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
    step();
    chk("beq_instr", out_instr, 32'h0000_0463);
    chk("beq_addr",  32'(out_addr), 32'd0);
    drive(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800);
    step();
    chk("jal_instr", out_instr, 32'h0010_00EF);
    chk("jal_addr",  32'(out_addr), 32'd1);
    chk("jal_err",   32'(out_err), 32'd0);

    // LUI good, then LUI with low immediate bits set
    drive(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    step();
    chk("lui_instr", out_instr, 32'h1234_52B7);
    chk("lui_err",   32'(out_err), 32'd0);
    chk("lui_addr",  32'(out_addr), 32'd2);
    drive(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5001);
    step();
    chk("lui_bad_instr", out_instr, 32'h1234_52B7);
    chk("lui_bad_err",   32'(out_err), 32'd1);
    in_valid = 1'b0;
    step();
    chk("lui_bad_errcnt", 32'(err_count), 32'd1);
    chk("lui_drained",    32'(out_valid), 32'd0);
    chk("lui_addr_after", 32'(out_addr),  32'd4);

    // Odd branch offset and oversize ADDI immediate
    pulse_start();
    chk("start_errcnt_clr", 32'(err_count), 32'd0);
    drive(7'h63, 5'd0, 3'd1, 5'd0, 5'd0, 7'd0, 32'd3);
    step();
    chk("bne_odd_instr", out_instr, 32'h0000_1163);
    chk("bne_odd_err",   32'(out_err), 32'd1);
    drive(7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    step();
    chk("addi_big_instr", out_instr, 32'h8000_0013);
    chk("addi_big_err",   32'(out_err), 32'd1);
    in_valid = 1'b0;
    step();
    chk("range_errcnt", 32'(err_count), 32'd2);

    // Shift-immediates, unknown opcode
    drive(7'h13, 5'd2, 3'd1, 5'd3, 5'd0, 7'h00, 32'd5);
    step();
    chk("slli_instr", out_instr, 32'h0051_9113);
    chk("slli_err",   32'(out_err), 32'd0);
    drive(7'h13, 5'd1, 3'd5, 5'd1, 5'd0, 7'h20, 32'd3);
    step();
    chk("srai_instr", out_instr, 32'h4030_D093);
    drive(7'h13, 5'd2, 3'd1, 5'd3, 5'd0, 7'h00, 32'd32);
    step();
    chk("slli_big_instr", out_instr, 32'h0001_9113);
    chk("slli_big_err",   32'(out_err), 32'd1);
    drive(7'h7F, 5'd1, 3'd1, 5'd1, 5'd1, 7'd1, 32'h0);
    step();
    chk("badop_instr", out_instr, 32'h0);
    chk("badop_err",   32'(out_err), 32'd1);
    in_valid = 1'b0;
    step();
    chk("badop_errcnt", 32'(err_count), 32'd4);

    // Store and R-type (R ignores the immediate)
    drive(7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 7'd0, 32'hFFFF_FFFC);
    step();
    chk("sw_instr", out_instr, 32'hFE21_AE23);
    chk("sw_err",   32'(out_err), 32'd0);
    drive(7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'hDEAD_BEEF);
    step();
    chk("add_instr", out_instr, 32'h0031_00B3);
    chk("add_err",   32'(out_err), 32'd0);
    in_valid = 1'b0;
    step();

    // Backpressure: 5 cycles with out_ready low
    out_ready = 1'b0;
    drive(7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'h0);
    step();
    chk("bp_ready_1", 32'(in_ready), 32'd1);
    drive(7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 7'd0, 32'hFFFF_FFFC);
    step();
    chk("bp_full", 32'(in_ready), 32'd0);
    drive(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    repeat (3) step();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_instr", out_instr, 32'h0031_00B3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_second", out_instr, 32'hFE21_AE23);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Start with a full FIFO at out_addr 0x3FF
    pulse_start();
    drive(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    repeat (1023) step();
    chk("run_addr_3ff", 32'(out_addr), 32'h3FF);
    out_ready = 1'b0;
    step();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_addr",     32'(out_addr), 32'h3FF);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("flush_valid",  32'(out_valid), 32'd0);
    chk("flush_instr",  out_instr, 32'h0);
    chk("flush_addr",   32'(out_addr), 32'd0);
    chk("flush_errcnt", 32'(err_count), 32'd0);

    // 1024 pops wrap out_addr back to 0
    step();
    repeat (1023) step();
    chk("wrap_pre", 32'(out_addr), 32'h3FF);
    step();
    chk("wrap_addr",  32'(out_addr), 32'd0);
    chk("wrap_valid", 32'(out_valid), 32'd1);
    step();
    chk("wrap_next", 32'(out_addr), 32'd1);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",    32'(out_valid), 32'd0);
    chk("arst_addr",     32'(out_addr),  32'd0);
    chk("arst_in_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
